// File: rtl/gravity_ctrl.sv
// gravity_ctrl: debounces the flip button, tracks grounded/airborne state and detects death for move_player.
// Optional feature: define GRAV_AIR_FLIP_EN to allow one gravity flip per airborne phase.
module gravity_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned DEATH_TOP       = 0,
  parameter int unsigned DEATH_BOTTOM    = 420
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       start,
  input  logic [8:0] height,
  input  logic [2:0] lines,
  output logic       grav_dir,
  output logic       is_dead,
  output logic [7:0] flip_count
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [8:0]       TOP_H   = 9'(DEATH_TOP);
  localparam logic [8:0]       BOT_H   = 9'(DEATH_BOTTOM);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GROUNDED,
    S_AIR,
    S_DEAD
  } state_t;

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             level;
  logic             level_next;
  logic             flip_req;
  logic             grounded_c;
  logic             oob_c;
  logic [7:0]       count_inc_c;
`ifdef GRAV_AIR_FLIP_EN
  logic             air_flip_ok;
`endif

  // Debounce: count consecutive high samples, drop the level on the first low one.
  always_comb begin
    cnt_next = '0;
    if (sync2) begin
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    end
    level_next = sync2 & (level | (cnt_next == CNT_MAX));
  end

  assign grounded_c = grav_dir ?
                      (((height == 9'd120) & lines[0]) | ((height == 9'd240) & lines[1])) :
                      (((height == 9'd180) & lines[1]) | ((height == 9'd300) & lines[2]));

  // A height wrapped below zero lands at the top of the 9-bit range and trips the bottom bound.
  assign oob_c       = (height <= TOP_H) | (height >= BOT_H);
  assign count_inc_c = (flip_count == 8'hFF) ? flip_count : flip_count + 8'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      cnt      <= '0;
      level    <= 1'b0;
      flip_req <= 1'b0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      cnt      <= cnt_next;
      level    <= level_next;
      flip_req <= level_next & ~level;
    end
  end

  // Player FSM; leaving the playfield wins over landing and flipping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      grav_dir   <= 1'b0;
      is_dead    <= 1'b1;
      flip_count <= '0;
`ifdef GRAV_AIR_FLIP_EN
      air_flip_ok <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_AIR;
            grav_dir <= 1'b0;
            is_dead  <= 1'b0;
`ifdef GRAV_AIR_FLIP_EN
            air_flip_ok <= 1'b1;
`endif
          end
        end
        S_AIR: begin
          if (oob_c) begin
            state   <= S_DEAD;
            is_dead <= 1'b1;
          end else if (grounded_c) begin
            state <= S_GROUNDED;
`ifdef GRAV_AIR_FLIP_EN
            air_flip_ok <= 1'b1;
          end else if (flip_req && air_flip_ok) begin
            grav_dir    <= ~grav_dir;
            flip_count  <= count_inc_c;
            air_flip_ok <= 1'b0;
`endif
          end
        end
        S_GROUNDED: begin
          if (oob_c) begin
            state   <= S_DEAD;
            is_dead <= 1'b1;
          end else if (flip_req) begin
            state      <= S_AIR;
            grav_dir   <= ~grav_dir;
            flip_count <= count_inc_c;
          end else if (!grounded_c) begin
            state <= S_AIR;
          end
        end
        S_DEAD: begin
          is_dead <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          is_dead <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gravity_ctrl.sv
// tb_gravity_ctrl: randomized and directed checks of gravity_ctrl against a behavioural player model.
// Honours GRAV_AIR_FLIP_EN the same way as the design.
module tb_gravity_ctrl;

  localparam int DEB = 16;
  localparam int TOP = 0;
  localparam int BOT = 420;

  localparam int M_IDLE = 0;
  localparam int M_GND  = 1;
  localparam int M_AIR  = 2;
  localparam int M_DEAD = 3;

`ifdef GRAV_AIR_FLIP_EN
  localparam bit AIR_FLIP = 1'b1;
`else
  localparam bit AIR_FLIP = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       btn;
  logic       start;
  logic [8:0] height;
  logic [2:0] lines;
  logic       grav_dir;
  logic       is_dead;
  logic [7:0] flip_count;

  int n_tests;
  int n_fail;

  // Reference model state: player mode, direction, flip total, air-flip permission,
  // and lengths of the button-high run as seen one, two and three samples ago.
  int m_st;
  int m_gd;
  int m_cnt;
  bit m_armed;
  int r1, r2, r3;

  gravity_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .DEATH_TOP      (TOP),
    .DEATH_BOTTOM   (BOT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .start     (start),
    .height    (height),
    .lines     (lines),
    .grav_dir  (grav_dir),
    .is_dead   (is_dead),
    .flip_count(flip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit on_ground(input int gd, input int h, input logic [2:0] ln);
    if (gd == 0) return (h == 180 && ln[1]) || (h == 300 && ln[2]);
    return (h == 120 && ln[0]) || (h == 240 && ln[1]);
  endfunction

  // A press is accepted three samples after the synchronised run first reaches DEB.
  task automatic model_edge();
    bit freq;
    bit gnd;
    bit oob;
    int run;
    if (!reset) begin
      m_st = M_IDLE; m_gd = 0; m_cnt = 0; m_armed = 1'b0;
      r1 = 0; r2 = 0; r3 = 0;
      return;
    end
    freq = (r3 == DEB);
    run  = btn ? ((r1 < 100000) ? r1 + 1 : r1) : 0;
    r3 = r2; r2 = r1; r1 = run;
    gnd = on_ground(m_gd, int'(height), lines);
    oob = (int'(height) <= TOP) || (int'(height) >= BOT);
    case (m_st)
      M_IDLE: if (start) begin m_st = M_AIR; m_gd = 0; m_armed = 1'b1; end
      M_AIR: begin
        if (oob) m_st = M_DEAD;
        else if (gnd) begin m_st = M_GND; m_armed = 1'b1; end
        else if (AIR_FLIP && freq && m_armed) begin
          m_gd = 1 - m_gd; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255; m_armed = 1'b0;
        end
      end
      M_GND: begin
        if (oob) m_st = M_DEAD;
        else if (freq) begin m_st = M_AIR; m_gd = 1 - m_gd; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255; end
        else if (!gnd) m_st = M_AIR;
      end
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("grav_dir", int'(grav_dir), m_gd);
    check("is_dead", int'(is_dead), (m_st == M_IDLE || m_st == M_DEAD) ? 1 : 0);
    check("flip_count", int'(flip_count), m_cnt);
  endtask

  function automatic int ground_h(input int gd);
    return (gd != 0) ? 240 : 180;
  endfunction

  // Press for hi samples then release for lo; optionally keep the player on the ground.
  task automatic press(input int hi, input int lo, input bit follow);
    for (int i = 0; i < hi + lo; i++) begin
      btn = (i < hi);
      if (follow) height = 9'(ground_h(m_gd));
      step();
    end
  endtask

  task automatic reset_and_land();
    reset = 1'b0; btn = 1'b0; start = 1'b0; height = 9'd100; lines = 3'b111;
    repeat (2) step();
    reset = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    height = 9'd180;
    repeat (2) step();
  endtask

  initial begin
    int k;
    int g0, c0;
    int left;
    n_tests = 0; n_fail = 0;
    m_st = M_IDLE; m_gd = 0; m_cnt = 0; m_armed = 1'b0; r1 = 0; r2 = 0; r3 = 0;
    reset = 1'b0; btn = 1'b0; start = 1'b0; height = 9'd100; lines = 3'b010;

    // Reset and start
    repeat (3) step();
    check("rst_dead", int'(is_dead), 1);
    check("rst_grav", int'(grav_dir), 0);
    check("rst_count", int'(flip_count), 0);
    reset = 1'b1;
    repeat (2) step();
    check("idle_dead", int'(is_dead), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_alive", int'(is_dead), 0);

    // Landing then flip latency
    for (int h = 100; h <= 180; h += 4) begin
      height = 9'(h);
      step();
    end
    btn = 1'b1;
    k = 0;
    while (grav_dir == 1'b0 && k < 40) begin
      step();
      k++;
    end
    check("flip_latency", k, 19);
    check("flip_count_1", int'(flip_count), 1);
    btn = 1'b0;
    step();
    height = 9'd240;
    repeat (2) step();

    // Bounce rejection
    press(10, 1, 1'b0);
    press(10, 5, 1'b0);
    check("bounce_grav", int'(grav_dir), 1);
    check("bounce_count", int'(flip_count), 1);

    // Air flip: first press only with the feature, second always dropped
    height = 9'd200;
    repeat (2) step();
    press(22, 3, 1'b0);
    check("airflip_grav", int'(grav_dir), AIR_FLIP ? 0 : 1);
    check("airflip_count", int'(flip_count), AIR_FLIP ? 2 : 1);
    press(22, 3, 1'b0);
    check("airflip2_grav", int'(grav_dir), AIR_FLIP ? 0 : 1);
    check("airflip2_count", int'(flip_count), AIR_FLIP ? 2 : 1);
    height = 9'(ground_h(m_gd));
    repeat (2) step();

    // Randomized play
    left = 0;
    for (int c = 0; c < 1500; c++) begin
      if (left == 0) begin
        btn = ~btn;
        left = int'($urandom_range(1, 25));
      end
      left--;
      start = 1'b0;
      if (m_st == M_IDLE || m_st == M_DEAD) begin
        start = ($urandom_range(0, 9) == 0);
        if (m_st == M_DEAD && $urandom_range(0, 19) == 0) reset = 1'b0;
        height = 9'd200;
      end else begin
        k = int'($urandom_range(0, 99));
        if (k < 65) height = 9'(($urandom_range(0, 1) == 0) ? ground_h(m_gd) : (m_gd != 0 ? 120 : 300));
        else if (k < 97) height = 9'($urandom_range(130, 290));
        else height = 9'($urandom);
      end
      lines = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      if ($urandom_range(0, 499) == 0) reset = 1'b0;
      step();
      reset = 1'b1;
    end
    start = 1'b0;

    // Death has priority over a simultaneous accepted flip
    reset_and_land();
    g0 = int'(grav_dir);
    c0 = int'(flip_count);
    btn = 1'b1;
    k = 0;
    while (m_st != M_DEAD && k < 40) begin
      height = (r3 == DEB) ? 9'd420 : 9'd180;
      step();
      k++;
    end
    check("death_dead", int'(is_dead), 1);
    check("death_grav", int'(grav_dir), g0);
    check("death_count", int'(flip_count), c0);
    btn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; step(); start = 1'b0; step();
    end
    height = 9'd180;
    press(20, 2, 1'b0);
    check("dead_sticky", int'(is_dead), 1);

    // Saturation
    reset_and_land();
    for (int i = 0; i < 262; i++) press(18, 2, 1'b1);
    check("sat_count", int'(flip_count), 255);

    // Wrap through zero while going up
    reset_and_land();
    press(20, 2, 1'b0);
    check("wrap_up", int'(grav_dir), 1);
    height = 9'd1;
    step();
    check("wrap_alive", int'(is_dead), 0);
    height = 9'd0;
    step();
    check("wrap_dead", int'(is_dead), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
